encode_8b10b_lanes: RTL and testbench

Parametrised, streaming successor to the single-byte frame encoder. Each beat carries LANES bytes, and every byte is encoded to 10 bits under IEEE 802.3 cl.36 8b/10b. The encoder supports control (K) characters and chains running disparity (RD) across lanes and beats. It sits between the frame/CRC builder and the serialiser, and uses valid/ready handshakes on both sides in place of the encode_en/encode_continue pair.

---
 rtl/encode_8b10b_pkg.sv | 50 +++++
 rtl/encode_8b10b_lane.sv | 49 ++++
 rtl/encode_8b10b_lanes.sv | 99 +++++++++
 tb/tb_encode_8b10b_lanes.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/encode_8b10b_pkg.sv
// Shared constants for the lane-parallel 8b/10b encoder: sub-block code tables
// (negative running disparity forms), legal control bytes and bit-order helpers.
package encode_8b10b_pkg;

   localparam logic [7:0] K28_5  = 8'hBC;
   localparam logic       RD_NEG = 1'b0;
   localparam logic       RD_POS = 1'b1;

   localparam int N_LEGAL_K = 12;
   localparam logic [7:0] LEGAL_K [N_LEGAL_K] = '{
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE
   };

   // abcdei, a in the MSB, indexed by EDCBA
   localparam logic [5:0] CODE_6B [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
   };
   localparam logic [5:0] CODE_K28_6B = 6'b001111;

   // fghj, f in the MSB, indexed by HGF; entry 7 is the primary P7 form
   localparam logic [3:0] CODE_4B [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
   };
   localparam logic [3:0] CODE_A7_4B = 4'b0111;
   // K28.y fghj when the character starts at RD-; the whole sub-block flips at RD+
   localparam logic [3:0] CODE_K28_4B [8] = '{
      4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000
   };

   function automatic logic is_legal_k(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_LEGAL_K; i++)
         if (b == LEGAL_K[i]) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [5:0] rev6(input logic [5:0] v);
      return {v[0], v[1], v[2], v[3], v[4], v[5]};
   endfunction

   function automatic logic [3:0] rev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

endpackage

// File: rtl/encode_8b10b_lane.sv
// Combinational single-byte 8b/10b encoder; RD in, RD out, so lanes chain in order.
module encode_8b10b_lane
   import encode_8b10b_pkg::*;
(
   input  logic [7:0] octet,
   input  logic       k,
   input  logic       rd_in,
   output logic [9:0] code,
   output logic       rd_next,
   output logic       k_err
);

   logic [4:0] x;
   logic [2:0] y;
   logic       k_ok;
   logic       k28;
   logic       a7;
   logic       rd_mid;
   logic [5:0] abcdei;
   logic [3:0] fghj;

   always_comb begin
      x      = octet[4:0];
      y      = octet[7:5];
      k_ok   = k && is_legal_k(octet);
      k28    = k_ok && (x == 5'd28);
      k_err  = k && !k_ok;

      abcdei = k28 ? CODE_K28_6B : CODE_6B[x];
      // D.7 has a balanced count yet still takes its complement at RD+
      if (rd_in == RD_POS && ($countones(abcdei) != 3 || x == 5'd7))
         abcdei = ~abcdei;
      rd_mid = rd_in ^ ($countones(abcdei) != 3);

      a7 = (rd_mid == RD_NEG && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
           (rd_mid == RD_POS && (x == 5'd11 || x == 5'd13 || x == 5'd14));
      if (k28) begin
         fghj = (rd_in == RD_NEG) ? CODE_K28_4B[y] : ~CODE_K28_4B[y];
      end else begin
         fghj = (y == 3'd7 && (k_ok || a7)) ? CODE_A7_4B : CODE_4B[y];
         if (rd_mid == RD_POS && ($countones(fghj) != 2 || y == 3'd3))
            fghj = ~fghj;
      end
      rd_next = rd_mid ^ ($countones(fghj) != 2);

      code = {rev4(fghj), rev6(abcdei)};
   end

endmodule

// File: rtl/encode_8b10b_lanes.sv
// Streaming multi-lane 8b/10b encoder: valid/ready in and out, one output register,
// running disparity chained lane to lane and beat to beat, optional K28.5 idle fill.
module encode_8b10b_lanes
   import encode_8b10b_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int IDLE_FILL = 1,
   parameter int ERR_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [8*LANES-1:0]    s_data,
   input  logic [LANES-1:0]      s_k,
   input  logic                  s_rd_clear,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [10*LANES-1:0]   m_data,
   output logic                  m_fill,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  rd_out,
   output logic                  code_err,
   output logic [ERR_W-1:0]      err_count
);

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                  load_src;
   logic                  load_fill;
   logic [LANES:0]        rd_chain_p0;
   logic [10*LANES-1:0]   code_p0;
   logic [LANES-1:0]      k_err_p0;

   logic [10*LANES-1:0]   data_p1;
   logic                  vld_p1;
   logic                  fill_p1;
   logic                  rd_p1;
   logic                  err_p1;
   logic [ERR_W-1:0]      err_cnt_p1;

   assign s_ready   = !vld_p1 || m_ready;
   assign load_src  = s_valid && s_ready;
   assign load_fill = (IDLE_FILL != 0) && !s_valid && s_ready;

   // p0: lane encoders, lane 0 seeded from the registered RD unless cleared
   assign rd_chain_p0[0] = (load_src && s_rd_clear) ? RD_NEG : rd_p1;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [7:0] octet_p0;
      logic       k_p0;
      assign octet_p0 = s_valid ? s_data[8*i +: 8] : K28_5;
      assign k_p0     = s_valid ? s_k[i] : 1'b1;

      encode_8b10b_lane u_lane (
         .octet   (octet_p0),
         .k       (k_p0),
         .rd_in   (rd_chain_p0[i]),
         .code    (code_p0[10*i +: 10]),
         .rd_next (rd_chain_p0[i+1]),
         .k_err   (k_err_p0[i])
      );
   end

   // p1: output register, held while the sink stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         data_p1    <= '0;
         fill_p1    <= 1'b0;
         rd_p1      <= RD_NEG;
         err_p1     <= 1'b0;
         err_cnt_p1 <= '0;
      end else begin
         err_p1 <= 1'b0;
         if (load_src || load_fill) begin
            vld_p1  <= 1'b1;
            data_p1 <= code_p0;
            fill_p1 <= load_fill;
            rd_p1   <= rd_chain_p0[LANES];
            if (load_src && |k_err_p0) begin
               err_p1     <= 1'b1;
               err_cnt_p1 <= sat_inc(err_cnt_p1);
            end
         end else if (m_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign m_valid   = vld_p1;
   assign m_data    = data_p1;
   assign m_fill    = fill_p1;
   assign rd_out    = rd_p1;
   assign code_err  = err_p1;
   assign err_count = err_cnt_p1;

endmodule

// File: tb/tb_encode_8b10b_lanes.sv
// Directed bench: a one-lane no-fill encoder with a 2-bit error counter and a
// two-lane idle-filling encoder, both checked against hand-computed symbols.
module tb_encode_8b10b_lanes;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one lane, no idle fill, 2-bit counter
   logic        a_rst;
   logic [7:0]  a_s_data;
   logic [0:0]  a_s_k;
   logic        a_s_rd_clear, a_s_valid, a_s_ready;
   logic [9:0]  a_m_data;
   logic        a_m_fill, a_m_valid, a_m_ready, a_rd_out, a_code_err;
   logic [1:0]  a_err_count;

   encode_8b10b_lanes #(.LANES(1), .IDLE_FILL(0), .ERR_W(2)) u_dut_a (
      .clk        (clk),
      .rst        (a_rst),
      .s_data     (a_s_data),
      .s_k        (a_s_k),
      .s_rd_clear (a_s_rd_clear),
      .s_valid    (a_s_valid),
      .s_ready    (a_s_ready),
      .m_data     (a_m_data),
      .m_fill     (a_m_fill),
      .m_valid    (a_m_valid),
      .m_ready    (a_m_ready),
      .rd_out     (a_rd_out),
      .code_err   (a_code_err),
      .err_count  (a_err_count)
   );

   // two lanes, idle fill, 16-bit counter
   logic        b_rst;
   logic [15:0] b_s_data;
   logic [1:0]  b_s_k;
   logic        b_s_rd_clear, b_s_valid, b_s_ready;
   logic [19:0] b_m_data;
   logic        b_m_fill, b_m_valid, b_m_ready, b_rd_out, b_code_err;
   logic [15:0] b_err_count;

   encode_8b10b_lanes #(.LANES(2), .IDLE_FILL(1), .ERR_W(16)) u_dut_b (
      .clk        (clk),
      .rst        (b_rst),
      .s_data     (b_s_data),
      .s_k        (b_s_k),
      .s_rd_clear (b_s_rd_clear),
      .s_valid    (b_s_valid),
      .s_ready    (b_s_ready),
      .m_data     (b_m_data),
      .m_fill     (b_m_fill),
      .m_valid    (b_m_valid),
      .m_ready    (b_m_ready),
      .rd_out     (b_rd_out),
      .code_err   (b_code_err),
      .err_count  (b_err_count)
   );

   typedef struct {
      logic [7:0] d;
      logic       k;
      logic [9:0] code;
      logic       rd;
   } a_vec_t;

   // one-lane data/K sequence; each row starts from the RD the previous row left
   a_vec_t a_vecs [8] = '{
      '{8'h00, 1'b0, 10'h0B9, 1'b0},   // D.0.0  RD-
      '{8'hBC, 1'b1, 10'h17C, 1'b1},   // K28.5  RD-
      '{8'hBC, 1'b1, 10'h283, 1'b0},   // K28.5  RD+
      '{8'h07, 1'b0, 10'h347, 1'b1},   // D.7.0  RD-
      '{8'h07, 1'b0, 10'h0B8, 1'b0},   // D.7.0  RD+
      '{8'hF1, 1'b0, 10'h3B1, 1'b1},   // D.17.7 RD- uses A7
      '{8'hEB, 1'b0, 10'h04B, 1'b0},   // D.11.7 RD+ uses A7
      '{8'hF7, 1'b1, 10'h057, 1'b0}    // K23.7  RD-
   };

   initial begin
      a_rst = 1'b1; a_s_data = '0; a_s_k = '0; a_s_rd_clear = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b1;
      b_rst = 1'b1; b_s_data = '0; b_s_k = '0; b_s_rd_clear = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b1;
      tick();
      tick();

      check("a_rst_valid", a_m_valid, 0);
      check("a_rst_data", a_m_data, 0);
      check("a_rst_rd", a_rd_out, 0);
      check("a_rst_errcnt", a_err_count, 0);
      check("b_rst_valid", b_m_valid, 0);
      check("b_rst_data", b_m_data, 0);
      check("b_rst_fill", b_m_fill, 0);
      check("b_rst_rd", b_rd_out, 0);
      check("b_rst_codeerr", b_code_err, 0);
      check("b_rst_ready", b_s_ready, 1);

      // ---------------- one lane ----------------
      a_rst = 1'b0;
      tick();
      check("a_nofill_idle", a_m_valid, 0);

      a_s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_s_data = a_vecs[i].d;
         a_s_k    = a_vecs[i].k;
         tick();
         check($sformatf("a_vec%0d_valid", i), a_m_valid, 1);
         check($sformatf("a_vec%0d_code", i), a_m_data, a_vecs[i].code);
         check($sformatf("a_vec%0d_rd", i), a_rd_out, a_vecs[i].rd);
         check($sformatf("a_vec%0d_codeerr", i), a_code_err, 0);
      end

      a_s_valid = 1'b0;
      tick();
      check("a_nofill_drop", a_m_valid, 0);

      // illegal K is sent as data and counted
      a_s_valid = 1'b1; a_s_data = 8'h00; a_s_k = 1'b1;
      tick();
      check("a_badk_code", a_m_data, 10'h0B9);
      check("a_badk_codeerr", a_code_err, 1);
      check("a_badk_cnt1", a_err_count, 1);
      a_s_valid = 1'b0;
      tick();
      check("a_badk_pulse_end", a_code_err, 0);
      check("a_badk_cnt_hold", a_err_count, 1);
      a_s_valid = 1'b1;
      tick();
      check("a_badk_cnt2", a_err_count, 2);
      tick();
      check("a_badk_cnt3", a_err_count, 3);
      tick();
      check("a_badk_sat", a_err_count, 3);
      check("a_badk_sat_pulse", a_code_err, 1);
      a_s_valid = 1'b0; a_s_k = 1'b0;

      // ---------------- two lanes ----------------
      b_rst = 1'b0;
      tick();
      check("b_fill_valid", b_m_valid, 1);
      check("b_fill_flag", b_m_fill, 1);
      check("b_fill_data", b_m_data, 20'hA0D7C);
      check("b_fill_rd", b_rd_out, 0);
      tick();
      check("b_fill2_data", b_m_data, 20'hA0D7C);
      check("b_fill2_flag", b_m_fill, 1);

      b_s_valid = 1'b1; b_s_data = {8'hBC, 8'hBC}; b_s_k = 2'b11;
      tick();
      check("b_kk_data", b_m_data, 20'hA0D7C);
      check("b_kk_fill", b_m_fill, 0);
      check("b_kk_rd", b_rd_out, 0);

      b_s_data = {8'hB5, 8'hBC}; b_s_k = 2'b01;
      tick();
      check("b_kd_data", b_m_data, 20'h5557C);
      check("b_kd_rd", b_rd_out, 1);

      b_s_rd_clear = 1'b1; b_s_data = {8'hBC, 8'hBC}; b_s_k = 2'b11;
      tick();
      check("b_rdclr_data", b_m_data, 20'hA0D7C);
      check("b_rdclr_rd", b_rd_out, 0);
      b_s_rd_clear = 1'b0;

      b_s_data = {8'hB5, 8'hBC}; b_s_k = 2'b01;
      tick();
      check("b_pre_bp_data", b_m_data, 20'h5557C);
      check("b_pre_bp_rd", b_rd_out, 1);

      b_m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("b_bp_ready", b_s_ready, 0);
         check("b_bp_valid", b_m_valid, 1);
         check("b_bp_data", b_m_data, 20'h5557C);
         check("b_bp_rd", b_rd_out, 1);
      end

      b_m_ready = 1'b1;
      tick();
      check("b_rel_data", b_m_data, 20'h55683);
      check("b_rel_rd", b_rd_out, 0);
      b_s_data = {8'h00, 8'h00}; b_s_k = 2'b00;
      tick();
      check("b_rel2_data", b_m_data, 20'h2E4B9);
      check("b_rel2_fill", b_m_fill, 0);
      b_s_valid = 1'b0;
      tick();
      check("b_rel3_fill", b_m_fill, 1);
      check("b_rel3_data", b_m_data, 20'hA0D7C);

      // two bad lanes in one beat count once
      b_s_valid = 1'b1; b_s_data = {8'h00, 8'h00}; b_s_k = 2'b11;
      tick();
      check("b_badk_data", b_m_data, 20'h2E4B9);
      check("b_badk_codeerr", b_code_err, 1);
      check("b_badk_cnt", b_err_count, 1);

      b_s_data = {8'hB5, 8'hBC}; b_s_k = 2'b01;
      tick();
      check("b_post_codeerr", b_code_err, 0);
      check("b_post_cnt", b_err_count, 1);
      check("b_post_rd", b_rd_out, 1);

      b_s_valid = 1'b0; b_m_ready = 1'b0;
      tick();
      check("b_hold_valid", b_m_valid, 1);
      check("b_hold_data", b_m_data, 20'h5557C);
      b_rst = 1'b1;
      tick();
      check("b_midrst_valid", b_m_valid, 0);
      check("b_midrst_rd", b_rd_out, 0);
      check("b_midrst_cnt", b_err_count, 0);
      check("b_midrst_data", b_m_data, 0);
      check("b_midrst_ready", b_s_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
